clk_div_gen: RTL and testbench
==============================

CLK_DIV_GEN -- requirements
Module: clk_div_gen

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, the number of independent output clock channels (1..16).
REQ-002 The block SHALL have parameter DIV_W, default 16, the width of each channel's divide ratio.
REQ-003 The block SHALL have parameter DEFAULT_DIV, default 4, the divide ratio loaded into every channel at reset.
REQ-004 Port clk, input, 1: sole clock; all logic is on the rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous assert and active-low.
REQ-006 Port cfg_valid, input, 1: a configuration request is presented.
REQ-007 Port cfg_ready, output, 1: the addressed channel can accept a request.
REQ-008 Port cfg_ch, input, $clog2(NUM_CH) (min 1): target channel index.
REQ-009 Port cfg_div, input, DIV_W: requested divide ratio D.
REQ-010 Port cfg_en, input, 1: requested enable state.
REQ-011 Port sync, input, 1: single-cycle phase-realign strobe for all running channels.
REQ-012 Port clk_out, output, NUM_CH: divided clocks.
REQ-013 Port ch_active, output, NUM_CH: channel is running.

Function
REQ-014 Each channel SHALL hold div_q (DIV_W), en_q, cnt (DIV_W), a pending slot (div, en, valid) and a registered clk_out bit.
REQ-015 A channel that is running SHALL step cnt each cycle: cnt becomes 0 when cnt == div_q-1, otherwise cnt+1.
REQ-016 On the same edge, clk_out SHALL register (cnt_next < div_q>>1), giving period D with D>>1 cycles high and D-(D>>1) cycles low; odd D puts the extra cycle in the low phase.
REQ-017 The first high cycle of clk_out SHALL appear one cycle after the channel starts.
REQ-018 A requested cfg_div < 2 SHALL be clamped to 2; this is the maximum frequency, clk/2 at 50% duty.
REQ-019 cfg_ready SHALL equal !pending_valid[cfg_ch], combinational on cfg_ch.
REQ-020 cfg_ch >= NUM_CH SHALL force cfg_ready = 1, and a transfer to that index SHALL be discarded.
REQ-021 A transfer occurs when cfg_valid && cfg_ready; it SHALL load the pending slot of cfg_ch.
REQ-022 A pending slot SHALL be applied, and its valid cleared, on the edge where either:
- the channel is idle (en_q = 0), in which case it applies on the cycle after the transfer; or
- the channel is running and cnt == div_q-1 (period boundary).
Settings SHALL never change mid-period, so no runt or glitch pulse is produced.
REQ-023 Applying en = 1 to an idle channel SHALL set cnt = 0 and start it; en = 1 applied at a boundary SHALL simply continue with the new div_q.
REQ-024 Applying en = 0 at a boundary SHALL stop the channel: cnt = 0 and clk_out = 0, held until re-enabled.
REQ-025 ch_active[i] SHALL equal en_q[i].
REQ-026 When sync = 1, every running channel without an applicable pending slot SHALL load cnt = 0 and clk_out = 1 (clk_out = 0 if div_q>>1 == 0 cannot occur given the clamp). All such channels then rise together.
REQ-027 If sync coincides with a period boundary that has a pending slot, the pending slot SHALL be applied first, and the channel then restarts at cnt = 0 with the new div_q.
REQ-028 sync SHALL have no effect on idle channels.
REQ-029 A transfer to channel i on the same edge its pending slot is being applied SHALL be impossible, because cfg_ready is low for that channel.
REQ-030 A transfer to a different channel on that edge SHALL proceed normally.
REQ-031 Channels SHALL be fully independent except for the shared sync input and the shared config port.

Reset
REQ-032 While rst_n = 0 the block SHALL hold: clk_out = 0, ch_active = 0, cnt = 0, en_q = 0, div_q = max(DEFAULT_DIV, 2), all pending valid = 0, and cfg_ready = 1.
REQ-033 Reset asserted mid-period SHALL force clk_out low immediately (asynchronously) and discard any pending configuration.
REQ-034 After rst_n deasserts, the first edge SHALL be able to accept a transfer.

Verification
REQ-035 Reset, then a transfer {ch 0, div 4, en 1}: clk_out[0] rises 2 cycles after the transfer, pattern 1100 repeating; ch_active[0] = 1.
REQ-036 Channel 1 running at div 5; a transfer {ch 1, div 2} mid-period: cfg_ready low until the boundary; the current 11000 completes, then 10 repeating with no short pulse.
REQ-037 A transfer {div 0} or {div 1}: the channel runs at div 2 (toggles every cycle).
REQ-038 Channels 0 at div 4 and 2 at div 6 at arbitrary phases, then one sync pulse: both clk_out bits high on the next cycle and both phase counters at 0.
REQ-039 A running channel receives {en 0}: clk_out finishes the current period's low phase, then stays 0; ch_active drops at the boundary.
REQ-040 rst_n pulsed low for 1 ns mid-high-phase with a pending update: clk_out is 0 at once, the pending update is lost, and cfg_ready = 1.

Source files
------------

// File: rtl/clk_div_gen_if.sv
// Configuration port of the clock divider: a valid/ready handshake carrying
// the target channel, its divide ratio and its enable state.
interface clk_div_gen_if #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 16
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic              cfg_en;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_div,
        output cfg_en,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_div,
        input  cfg_en,
        output cfg_ready
    );
endinterface

// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock divider. Each channel produces a registered
// divided clock with period D (D>>1 cycles high, the rest low). New settings are
// parked in a per-channel pending slot and only take effect when the channel is
// idle or at a period boundary, so an output never shows a runt pulse. A shared
// sync strobe realigns all running channels so they rise together.
module clk_div_gen #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    clk_div_gen_if.slave      cfg,
    input  logic              sync,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] ch_active
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [DIV_W-1:0] MIN_DIV   = DIV_W'(2);
    localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);
    localparam logic [DIV_W-1:0] RESET_DIV = (DEFAULT_DIV < 2) ? DIV_W'(2) : DIV_W'(DEFAULT_DIV);

    logic [NUM_CH-1:0] pend_valid;
    logic [DIV_W-1:0]  cfg_div_clamped;
    logic              ready;
    logic              xfer;

    // Ratios below 2 cannot form a clock; clamp to the fastest legal rate.
    assign cfg_div_clamped = (cfg.cfg_div < MIN_DIV) ? MIN_DIV : cfg.cfg_div;

    // Ready reflects the addressed channel's pending slot; unknown indices
    // always accept so a stray request cannot stall the port.
    always_comb begin
        ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg.cfg_ch == CH_W'(i)) begin
                ready = !pend_valid[i];
            end
        end
    end

    assign cfg.cfg_ready = ready;
    assign xfer          = cfg.cfg_valid && ready;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [DIV_W-1:0] div_q;
        logic [DIV_W-1:0] div_next;
        logic [DIV_W-1:0] cnt;
        logic [DIV_W-1:0] cnt_next;
        logic [DIV_W-1:0] pend_div;
        logic             pend_en;
        logic             pend_v;
        logic             en_q;
        logic             en_next;
        logic             start_q;
        logic             start_next;
        logic             clk_q;
        logic             clk_next;
        logic             load;
        logic             boundary;
        logic             apply;

        // start_q marks the single settle cycle after an idle channel is
        // enabled; the first high cycle follows it, so no period is shortened.
        assign load     = xfer && (cfg.cfg_ch == CH_W'(gi));
        assign boundary = en_q && !start_q && (cnt == div_q - ONE);
        assign apply    = pend_v && (!en_q || boundary);

        // Next phase counter, settings and output level for this channel.
        always_comb begin
            div_next   = div_q;
            en_next    = en_q;
            cnt_next   = cnt;
            start_next = start_q;
            clk_next   = clk_q;
            if (apply) begin
                div_next   = pend_div;
                en_next    = pend_en;
                cnt_next   = '0;
                start_next = pend_en && !en_q;
                // Stopping or freshly starting channels stay low; a boundary
                // update opens the first period at the new ratio.
                clk_next   = pend_en && en_q && (cnt_next < (pend_div >> 1));
            end else if (en_q) begin
                if (sync || start_q) begin
                    cnt_next   = '0;
                    start_next = 1'b0;
                end else begin
                    cnt_next = boundary ? '0 : cnt + ONE;
                end
                clk_next = (cnt_next < (div_q >> 1));
            end
        end

        // Pending slot: loaded by a transfer, released when applied.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pend_v   <= 1'b0;
                pend_div <= RESET_DIV;
                pend_en  <= 1'b0;
            end else if (load) begin
                pend_v   <= 1'b1;
                pend_div <= cfg_div_clamped;
                pend_en  <= cfg.cfg_en;
            end else if (apply) begin
                pend_v   <= 1'b0;
            end
        end

        // Channel state register.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                div_q   <= RESET_DIV;
                en_q    <= 1'b0;
                cnt     <= '0;
                start_q <= 1'b0;
                clk_q   <= 1'b0;
            end else begin
                div_q   <= div_next;
                en_q    <= en_next;
                cnt     <= cnt_next;
                start_q <= start_next;
                clk_q   <= clk_next;
            end
        end

        assign clk_out[gi]    = clk_q;
        assign ch_active[gi]  = en_q;
        assign pend_valid[gi] = pend_v;
    end
endmodule

// File: tb/tb_clk_div_gen.sv
// Directed bench for clk_div_gen: start-up latency, mid-period updates,
// ratio clamping, sync realignment, disable at boundary and async reset.
module tb_clk_div_gen;
    localparam int NUM_CH = 4;
    localparam int DIV_W  = 16;
    localparam int CH_W   = 2;

    logic              clk;
    logic              rst_n;
    logic              sync;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] ch_active;

    int n_checks = 0;
    int n_fail   = 0;

    clk_div_gen_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) cfg_if ();

    clk_div_gen #(
        .NUM_CH(NUM_CH),
        .DIV_W(DIV_W),
        .DEFAULT_DIV(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cfg(cfg_if),
        .sync(sync),
        .clk_out(clk_out),
        .ch_active(ch_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request for one edge (the port must be ready), then drop valid.
    task automatic send(input int ch, input int div, input logic en);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = CH_W'(ch);
        cfg_if.cfg_div   = DIV_W'(div);
        cfg_if.cfg_en    = en;
        step();
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic set_ch(input int ch);
        cfg_if.cfg_ch = CH_W'(ch);
        #1;
    endtask

    initial begin
        logic [7:0] pat_a;
        logic [3:0] pat_c;
        logic [7:0] pat_e_clk;
        logic [7:0] pat_e_act;
        logic [5:0] pat_f;
        logic [3:0] exp_d [7];

        rst_n            = 1'b0;
        sync             = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch    = '0;
        cfg_if.cfg_div   = '0;
        cfg_if.cfg_en    = 1'b0;
        step(3);

        // Reset state
        chk("rst_clk_out", 32'(clk_out), 32'h0);
        chk("rst_active", 32'(ch_active), 32'h0);
        chk("rst_ready_ch0", 32'(cfg_if.cfg_ready), 32'h1);
        set_ch(3);
        chk("rst_ready_ch3", 32'(cfg_if.cfg_ready), 32'h1);
        rst_n = 1'b1;

        // Start channel 0 at div 4 on the first edge after reset
        send(0, 4, 1'b1);
        chk("a_ready_pending", 32'(cfg_if.cfg_ready), 32'h0);
        chk("a_clk_xfer", 32'(clk_out[0]), 32'h0);
        chk("a_active_xfer", 32'(ch_active), 32'h0);
        step();
        chk("a_active_start", 32'(ch_active), 32'h1);
        chk("a_clk_start", 32'(clk_out[0]), 32'h0);
        chk("a_ready_applied", 32'(cfg_if.cfg_ready), 32'h1);
        pat_a = 8'b11001100;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("a_div4_pattern", 32'(clk_out[0]), 32'(pat_a[7-i]));
        end

        // Channel 1 at div 5, retuned to div 2 mid-period
        send(1, 5, 1'b1);
        step();
        chk("b_active_start", 32'(ch_active), 32'h3);
        step();
        chk("b_d5_hi0", 32'(clk_out[1]), 32'h1);
        step();
        chk("b_d5_hi1", 32'(clk_out[1]), 32'h1);
        send(1, 2, 1'b1);
        chk("b_ready_hold0", 32'(cfg_if.cfg_ready), 32'h0);
        chk("b_d5_lo0", 32'(clk_out[1]), 32'h0);
        step();
        chk("b_ready_hold1", 32'(cfg_if.cfg_ready), 32'h0);
        chk("b_d5_lo1", 32'(clk_out[1]), 32'h0);
        step();
        chk("b_ready_hold2", 32'(cfg_if.cfg_ready), 32'h0);
        chk("b_d5_lo2", 32'(clk_out[1]), 32'h0);
        // Another channel is accepted on the edge channel 1 applies
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = CH_W'(2);
        cfg_if.cfg_div   = DIV_W'(6);
        cfg_if.cfg_en    = 1'b1;
        #1;
        chk("b_ready_other_ch", 32'(cfg_if.cfg_ready), 32'h1);
        step();
        cfg_if.cfg_valid = 1'b0;
        set_ch(1);
        chk("b_ready_released", 32'(cfg_if.cfg_ready), 32'h1);
        chk("b_d2_hi0", 32'(clk_out[1]), 32'h1);
        step();
        chk("b_d2_lo0", 32'(clk_out[1]), 32'h0);
        chk("b_active_ch2", 32'(ch_active), 32'h7);
        step();
        chk("b_d2_hi1", 32'(clk_out[1]), 32'h1);
        step();
        chk("b_d2_lo1", 32'(clk_out[1]), 32'h0);

        // Ratio 0 and ratio 1 both clamp to 2
        send(3, 0, 1'b1);
        step();
        chk("c_clk_start", 32'(clk_out[3]), 32'h0);
        chk("c_active_all", 32'(ch_active), 32'hf);
        pat_c = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("c_div0_pattern", 32'(clk_out[3]), 32'(pat_c[3-i]));
        end
        send(3, 1, 1'b1);
        chk("c_div1_hi_xfer", 32'(clk_out[3]), 32'h1);
        chk("c_ready_pending", 32'(cfg_if.cfg_ready), 32'h0);
        step();
        chk("c_div1_lo0", 32'(clk_out[3]), 32'h0);
        step();
        chk("c_div1_hi_applied", 32'(clk_out[3]), 32'h1);
        chk("c_ready_applied", 32'(cfg_if.cfg_ready), 32'h1);
        step();
        chk("c_div1_lo1", 32'(clk_out[3]), 32'h0);

        // Sync realigns every running channel
        step();
        exp_d = '{4'b1111, 4'b0101, 4'b1110, 4'b0000, 4'b1011, 4'b0001, 4'b1110};
        sync = 1'b1;
        step();
        sync = 1'b0;
        chk("d_sync_all_high", 32'(clk_out), 32'(exp_d[0]));
        for (int i = 1; i < 7; i++) begin
            step();
            chk("d_after_sync", 32'(clk_out), 32'(exp_d[i]));
        end

        // Disable channel 2 (div 6) partway through its high phase
        send(2, 6, 1'b0);
        pat_e_clk = 8'b11000000;
        pat_e_act = 8'b11111000;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            chk("e_disable_clk", 32'(clk_out[2]), 32'(pat_e_clk[7-i]));
            chk("e_disable_active", 32'(ch_active[2]), 32'(pat_e_act[7-i]));
        end

        // Async reset during a high phase with a pending update
        step(2);
        chk("f_ch0_high", 32'(clk_out[0]), 32'h1);
        send(0, 8, 1'b1);
        chk("f_ch0_still_high", 32'(clk_out[0]), 32'h1);
        chk("f_ready_pending", 32'(cfg_if.cfg_ready), 32'h0);
        rst_n = 1'b0;
        #1;
        chk("f_rst_clk_out", 32'(clk_out), 32'h0);
        chk("f_rst_active", 32'(ch_active), 32'h0);
        chk("f_rst_ready", 32'(cfg_if.cfg_ready), 32'h1);
        rst_n = 1'b1;
        step();
        chk("f_pending_lost_act0", 32'(ch_active), 32'h0);
        chk("f_pending_lost_clk0", 32'(clk_out), 32'h0);
        step();
        chk("f_pending_lost_act1", 32'(ch_active), 32'h0);
        chk("f_pending_lost_clk1", 32'(clk_out), 32'h0);

        // Odd ratio after reset: extra cycle goes to the low phase
        send(0, 3, 1'b1);
        step();
        chk("g_active_start", 32'(ch_active), 32'h1);
        pat_f = 6'b100100;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("g_div3_pattern", 32'(clk_out[0]), 32'(pat_f[5-i]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
